// File: rtl/uart_rx_recv_if.sv
// Consumer-side bundle of the UART receiver: received word, read strobe, status.
// Latency: none, wires only.
// Backpressure: the consumer acknowledges with ren; an unread word is overwritten by the next one and ovr is flagged.
interface uart_rx_recv_if #(
  parameter int DW = 8
);
  logic          ren;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          ferr;
  logic          ovr;
  logic          busy;

  // Receiver side drives data and status, samples the read strobe.
  modport master (
    input  ren,
    output dout, dvalid, ferr, ovr, busy
  );

  // Consumer side issues reads and observes data and status.
  modport slave (
    output ren,
    input  dout, dvalid, ferr, ovr, busy
  );
endinterface

// File: rtl/uart_rx_recv.sv
// UART receiver (8N1 by default, LSB first, idle high) with framing/overrun reporting.
// Latency: dvalid rises 1 clk after the stop-bit sample, about DW+1.5 bit times after the start edge plus 3 clk (sync + edge detect).
// Backpressure: none on the line; an unread word is overwritten by the next one and ovr pulses.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at cnt==2,1,0 (needs SLOOP_MAX/2 >= 3).
module uart_rx_recv #(
  parameter int CLK_FREQ  = 10,
  parameter int BAUDRATE  = 9600,
  parameter int SLOOP_MAX = CLK_FREQ * 1000 * 1000 / BAUDRATE,
  parameter int DW        = 8
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          RX,
  uart_rx_recv_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  localparam int          BCW  = $clog2(DW + 1);
  localparam logic [31:0] HALF = 32'(SLOOP_MAX / 2 - 1);
  localparam logic [31:0] FULL = 32'(SLOOP_MAX - 1);
  localparam logic [BCW-1:0] LAST = BCW'(DW - 1);

  logic [2:0]     state;
  logic [31:0]    cnt;
  logic [BCW-1:0] bcnt;
  logic [DW-1:0]  sr;
  logic [DW-1:0]  dout;
  logic           dvalid;
  logic           ferr;
  logic           ovr;
  logic           rx_m, rx_s, rx_d;
  logic           fall;
  logic           smp;
  logic           at_smp;

  // Two-flop synchroniser for the asynchronous RX pin, plus a delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign at_smp = (cnt == 32'd0);

`ifdef UART_RX_MAJORITY_EN
  logic smp2, smp1;

  // Capture the two samples preceding each sample point for the 2-of-3 vote.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      smp2 <= 1'b1;
      smp1 <= 1'b1;
    end else begin
      if (cnt == 32'd2) smp2 <= rx_s;
      if (cnt == 32'd1) smp1 <= rx_s;
    end
  end

  assign smp = (smp2 & smp1) | (smp2 & rx_s) | (smp1 & rx_s);
`else
  assign smp = rx_s;
`endif

  // Frame FSM: start-bit qualification, data shift-in, stop check, break wait, read handshake.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state  <= IDLE;
      cnt    <= 32'd0;
      bcnt   <= '0;
      sr     <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
      if (bus.ren && dvalid) dvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= HALF;
            state <= START;
          end
        end
        START: begin
          if (at_smp) begin
            if (!smp) begin
              cnt   <= FULL;
              bcnt  <= '0;
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (at_smp) begin
            sr   <= {smp, sr[DW-1:1]};
            cnt  <= FULL;
            bcnt <= bcnt + BCW'(1);
            if (bcnt == LAST) state <= STOP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          if (at_smp) begin
            if (smp) begin
              dout   <= sr;
              dvalid <= 1'b1;
              ovr    <= dvalid & ~bus.ren;
              state  <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= BRK;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout   = dout;
  assign bus.dvalid = dvalid;
  assign bus.ferr   = ferr;
  assign bus.ovr    = ovr;
  assign bus.busy   = (state != IDLE);

endmodule
